// File: rtl/vga_img_pkg.sv
// Image geometry and pixel widths shared by the VGA/ROM path, the Sobel block and the colouriser.
package vga_img_pkg;

    localparam int IMG_W       = 200;
    localparam int IMG_H       = 200;
    localparam int DW          = 8;
    localparam int OW          = 11;
    localparam int SOBEL_LAT   = 3;
    localparam int EDGE_THRESH = 100;

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of gray pixels with a registered read.
// If a read and a write hit the same address on the same edge, the read returns the old data.
module sobel_line_buf #(
    parameter int DEPTH = 200,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sobel_edge_detect.sv
// Streaming 3x3 Sobel edge detector: row/col tracking, two line buffers, window,
// gradient stage and |Gx|+|Gy| stage with a matching valid/border delay line.
module sobel_edge_detect
    import vga_img_pkg::*;
#(
    parameter int IMG_W = vga_img_pkg::IMG_W,
    parameter int IMG_H = vga_img_pkg::IMG_H,
    parameter int DW    = vga_img_pkg::DW,
    parameter int OW    = vga_img_pkg::OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          pix_en,
    input  logic [DW-1:0] gray,
    output logic [OW-1:0] sobel_data,
    output logic          display_val
);

    localparam int AW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = DW + 3;

    logic [AW-1:0] col, col_acc, col_nxt, rd_addr;
    logic [RW-1:0] row, row_acc, row_nxt;
    logic          border_c;

    always_comb begin
        col_acc = frame_start ? '0 : col;
        row_acc = frame_start ? '0 : row;
        col_nxt = col_acc;
        row_nxt = row_acc;
        if (pix_en) begin
            if (col_acc == AW'(IMG_W - 1)) begin
                col_nxt = '0;
                row_nxt = (row_acc == RW'(IMG_H - 1)) ? '0 : row_acc + 1'b1;
            end else begin
                col_nxt = col_acc + 1'b1;
            end
        end
        // Reads run one pixel ahead so the registered RAM output is ready on the accepting edge.
        rd_addr  = rst ? '0 : col_nxt;
        border_c = (col_acc < AW'(2)) || (row_acc < RW'(2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    logic          lb_wr;
    logic [DW-1:0] lb1_q, lb0_q;

    assign lb_wr = pix_en && !rst;

    sobel_line_buf #(.DEPTH(IMG_W), .W(DW), .AW(AW)) u_lb1 (
        .clk     (clk),
        .wr_en   (lb_wr),
        .wr_addr (col_acc),
        .wr_data (gray),
        .rd_addr (rd_addr),
        .rd_data (lb1_q)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .W(DW), .AW(AW)) u_lb0 (
        .clk     (clk),
        .wr_en   (lb_wr),
        .wr_addr (col_acc),
        .wr_data (lb1_q),
        .rd_addr (rd_addr),
        .rd_data (lb0_q)
    );

    logic [DW-1:0] p [3][3];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    p[i][j] <= '0;
                end
            end
        end else if (pix_en) begin
            for (int i = 0; i < 3; i++) begin
                p[i][0] <= p[i][1];
                p[i][1] <= p[i][2];
            end
            p[0][2] <= lb0_q;
            p[1][2] <= lb1_q;
            p[2][2] <= gray;
        end
    end

    logic signed [GW-1:0] q [3][3];
    logic signed [GW-1:0] gx_c, gy_c, gx, gy;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                q[i][j] = signed'(GW'(p[i][j]));
            end
        end
        gx_c = (q[0][2] + (q[1][2] <<< 1) + q[2][2]) - (q[0][0] + (q[1][0] <<< 1) + q[2][0]);
        gy_c = (q[2][0] + (q[2][1] <<< 1) + q[2][2]) - (q[0][0] + (q[0][1] <<< 1) + q[0][2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx <= '0;
            gy <= '0;
        end else begin
            gx <= gx_c;
            gy <= gy_c;
        end
    end

    logic [GW-1:0] gx_abs, gy_abs;
    logic [OW-1:0] mag_c;

    always_comb begin
        gx_abs = gx[GW-1] ? GW'(-gx) : GW'(gx);
        gy_abs = gy[GW-1] ? GW'(-gy) : GW'(gy);
        mag_c  = OW'(gx_abs) + OW'(gy_abs);
    end

    // Bit k of each pipe describes the pixel sitting in stage k+1 of the datapath.
    logic [SOBEL_LAT-1:0] v_pipe;
    logic [SOBEL_LAT-2:0] b_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe     <= '0;
            b_pipe     <= '0;
            sobel_data <= '0;
        end else begin
            v_pipe <= {v_pipe[SOBEL_LAT-2:0], pix_en};
            b_pipe <= {b_pipe[SOBEL_LAT-3:0], border_c};
            if (v_pipe[SOBEL_LAT-2]) begin
                sobel_data <= b_pipe[SOBEL_LAT-2] ? '0 : mag_c;
            end
        end
    end

    assign display_val = v_pipe[SOBEL_LAT-1];

endmodule
